// File: rtl/reg_mem_seq.sv
// Burst sequencer driving a reg_mem word store.
// Streams write bursts in and read bursts out over valid/ready.
module reg_mem_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_BITS-1:0]  cmd_addr,
    input  logic [ADDR_BITS-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WRITE   = 3'd1;
    localparam logic [2:0] RD_ADDR = 3'd2;
    localparam logic [2:0] RD_WAIT = 3'd3;
    localparam logic [2:0] RD_CAP  = 3'd4;
    localparam logic [2:0] RD_OUT  = 3'd5;

    logic [2:0]           state;
    logic [ADDR_BITS-1:0] ptr;
    logic [ADDR_BITS-1:0] cnt;
    logic                 last;

    assign last = (cnt == '0);

    // Burst FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            cmd_ready   <= 1'b0;
            wr_ready    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            busy        <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            mem_wen     <= 1'b0;
        end else begin
            mem_wen <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!cmd_ready) begin
                        cmd_ready <= 1'b1;
                    end else if (cmd_valid) begin
                        ptr       <= cmd_addr;
                        cnt       <= cmd_len;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_write) begin
                            wr_ready <= 1'b1;
                            state    <= WRITE;
                        end else begin
                            state <= RD_ADDR;
                        end
                    end
                end
                WRITE: begin
                    if (wr_valid && wr_ready) begin
                        mem_addr    <= ptr;
                        mem_data_in <= wr_data;
                        mem_wen     <= 1'b1;
                        ptr         <= ptr + 1'b1;
                        if (last) begin
                            wr_ready  <= 1'b0;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    mem_addr <= ptr;
                    state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    rd_data  <= mem_data_out;
                    rd_valid <= 1'b1;
                    state    <= RD_OUT;
                end
                RD_OUT: begin
                    if (rd_valid && rd_ready) begin
                        rd_valid <= 1'b0;
                        if (last) begin
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            cnt   <= cnt - 1'b1;
                            state <= RD_ADDR;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_mem_seq.sv
// Self-checking bench for reg_mem_seq with a reg_mem stand-in.
// Scoreboard queues hold expected writes and read beats.
module tb_reg_mem_seq;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [4:0] cmd_addr;
    logic [4:0] cmd_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       busy;
    logic [4:0] mem_addr;
    logic [7:0] mem_data_in;
    logic       mem_wen;
    logic [7:0] mem_data_out;

    reg_mem_seq #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data(wr_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_data(rd_data),
        .busy(busy),
        .mem_addr(mem_addr),
        .mem_data_in(mem_data_in),
        .mem_wen(mem_wen),
        .mem_data_out(mem_data_out)
    );

    // reg_mem stand-in: write on edge, combinational read
    logic [7:0] mem [32];
    always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_data_in;
    assign mem_data_out = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_hs = -1;
    bit chk_spacing = 1'b0;

    logic [12:0] wq[$];
    logic [7:0]  rq[$];
    logic [7:0]  shadow [32];

    logic       stalled = 1'b0;
    logic [7:0] st_data;
    logic [4:0] st_addr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: pops scoreboard entries as the DUT produces them
    always @(negedge clk) begin
        logic [12:0] e;
        logic [7:0]  d;
        if (mem_wen === 1'b1) begin
            if (wq.size() == 0) begin
                chk("unexp_wen", {mem_addr, mem_data_in}, 0);
            end else begin
                e = wq.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e[12:8]));
                chk("wr_data", 32'(mem_data_in), 32'(e[7:0]));
            end
        end
        if (rst_n && stalled) begin
            chk("stall_valid", 32'(rd_valid), 1);
            chk("stall_data", 32'(rd_data), 32'(st_data));
            chk("stall_addr", 32'(mem_addr), 32'(st_addr));
        end
        stalled = rst_n && rd_valid && !rd_ready;
        st_data = rd_data;
        st_addr = mem_addr;
        if (rst_n && rd_valid === 1'b1 && rd_ready === 1'b1) begin
            if (rq.size() == 0) begin
                chk("unexp_rd", 32'(rd_data), 32'hffff);
            end else begin
                d = rq.pop_front();
                chk("rd_data", 32'(rd_data), 32'(d));
            end
            if (chk_spacing && last_hs >= 0)
                chk("rd_spacing", cyc - last_hs, 4);
            last_hs = cyc;
        end
    end

    task automatic send_cmd(input logic w, input logic [4:0] a,
                            input logic [4:0] l);
        int n;
        logic [4:0] p;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        if (!w) begin
            for (int i = 0; i <= int'(l); i++) begin
                p = a + 5'(i);
                rq.push_back(shadow[p]);
            end
        end
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("cmd_timeout", 0, 1);
        else tick();
        cmd_valid = 1'b0;
    endtask

    task automatic write_beats(input logic [4:0] a, input int cnt,
                               input logic [7:0] base, input bit gaps);
        int n;
        logic [4:0] p;
        for (int i = 0; i < cnt; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 8'(i);
            n = 0;
            while (!wr_ready && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) begin
                chk("wr_timeout", 0, 1);
                wr_valid = 1'b0;
                return;
            end
            p = a + 5'(i);
            wq.push_back({p, wr_data});
            shadow[p] = wr_data;
            tick();
            if (gaps) begin
                wr_valid = 1'b0;
                tick();
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || rq.size() != 0 || wq.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n < 400), 1);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 5'd3;
        cmd_len   = 5'd0;
        wr_valid  = 1'b1;
        wr_data   = 8'hee;
        rd_ready  = 1'b1;

        // reset with traffic offered
        repeat (3) begin
            tick();
            chk("rst_outs", {cmd_ready, wr_ready, rd_valid, busy, mem_wen,
                             rd_data, mem_addr, mem_data_in}, 0);
        end
        rst_n = 1'b1;
        chk("cmd_ready_pre", 32'(cmd_ready), 0);
        tick();
        chk("cmd_ready_up", 32'(cmd_ready), 1);
        chk("busy_idle", 32'(busy), 0);
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        tick();

        // basic write then read, read beats 4 cycles apart
        send_cmd(1'b1, 5'd12, 5'd7);
        write_beats(5'd12, 8, 8'd10, 1'b0);
        wait_idle();
        chk_spacing = 1'b1;
        last_hs = -1;
        send_cmd(1'b0, 5'd12, 5'd7);
        wait_idle();
        chk_spacing = 1'b0;

        // address wrap
        send_cmd(1'b1, 5'd30, 5'd3);
        write_beats(5'd30, 4, 8'ha0, 1'b0);
        wait_idle();
        send_cmd(1'b0, 5'd30, 5'd3);
        wait_idle();

        // write with gaps
        send_cmd(1'b1, 5'd20, 5'd4);
        write_beats(5'd20, 5, 8'h60, 1'b1);
        wait_idle();

        // read with consumer stall on beat 2
        send_cmd(1'b0, 5'd20, 5'd4);
        n = 0;
        while (!rd_valid && n < 20) begin
            tick();
            n++;
        end
        tick();
        rd_ready = 1'b0;
        n = 0;
        while (!rd_valid && n < 20) begin
            tick();
            n++;
        end
        chk("rd_beat2_seen", 32'(rd_valid), 1);
        repeat (5) tick();
        rd_ready = 1'b1;
        wait_idle();

        // command arbitration with cmd_valid held
        cmd_write = 1'b1;
        cmd_addr  = 5'd5;
        cmd_len   = 5'd0;
        cmd_valid = 1'b1;
        tick();
        chk("arb_ready_lo", 32'(cmd_ready), 0);
        chk("arb_busy_hi", 32'(busy), 1);
        cmd_write = 1'b0;
        wr_valid  = 1'b1;
        wr_data   = 8'h55;
        wq.push_back({5'd5, 8'h55});
        shadow[5] = 8'h55;
        rq.push_back(8'h55);
        tick();
        wr_valid = 1'b0;
        chk("arb_ready_back", 32'(cmd_ready), 1);
        chk("arb_busy_lo", 32'(busy), 0);
        chk("arb_wr_ready_lo", 32'(wr_ready), 0);
        tick();
        chk("arb_second_acc", {busy, cmd_ready}, 2'b10);
        cmd_valid = 1'b0;
        wait_idle();

        // full-depth burst from address 3
        send_cmd(1'b1, 5'd3, 5'd31);
        write_beats(5'd3, 32, 8'h40, 1'b0);
        wait_idle();
        chk("full_last_addr", 32'(mem_addr), 2);
        send_cmd(1'b0, 5'd3, 5'd31);
        wait_idle();

        // reset in the middle of a write burst
        send_cmd(1'b1, 5'd12, 5'd7);
        write_beats(5'd12, 3, 8'hc0, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_wen", 32'(mem_wen), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_wq", wq.size(), 0);
        wr_valid = 1'b1;
        wr_data  = 8'hdd;
        tick();
        chk("mid_rst_wen2", 32'(mem_wen), 0);
        wr_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        send_cmd(1'b0, 5'd12, 5'd3);
        wait_idle();
        chk("rq_drained", rq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_mem_seq.md
Name: reg_mem_seq

Overview:
- Burst sequencer directly upstream of reg_mem. It owns reg_mem's addr, data_in and wen pins and reads its data_out.
- Accepts one burst command at a time (start address, beat count, direction) over a valid/ready handshake.
- Write bursts: streams write beats from a valid/ready producer into consecutive addresses.
- Read bursts: returns stored words to a valid/ready consumer.

Parameters:
- DATA_WIDTH, 8, word width; must match reg_mem DATA_WIDTH.
- ADDR_BITS, 5, address width; must match reg_mem ADDR_BITS (depth 2^ADDR_BITS).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_BITS  burst start address.
- cmd_len  in  ADDR_BITS  beats minus one (0 gives 1 beat, all-ones gives 2^ADDR_BITS beats).
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  write beat accepted.
- wr_data  in  DATA_WIDTH  write beat data.
- rd_valid  out  1  read beat available.
- rd_ready  in  1  consumer accepts read beat.
- rd_data  out  DATA_WIDTH  read beat data.
- busy  out  1  burst in progress (state not IDLE).
- mem_addr  out  ADDR_BITS  drives reg_mem addr.
- mem_data_in  out  DATA_WIDTH  drives reg_mem data_in.
- mem_wen  out  1  drives reg_mem wen.
- mem_data_out  in  DATA_WIDTH  from reg_mem data_out.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n. All outputs are registered.
- Reset values (while rst_n is low at an edge): every output is 0 and state is IDLE. cmd_ready rises on the first edge after rst_n goes high.
- Internal state:
  - ptr, ADDR_BITS wide.
  - cnt, ADDR_BITS wide, remaining beats minus one.
  - FSM states IDLE, WRITE, RD_ADDR, RD_WAIT, RD_CAP, RD_OUT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: ptr<=cmd_addr, cnt<=cmd_len, cmd_ready<=0, busy<=1.
  - Next state is WRITE if cmd_write=1, else RD_ADDR.
- WRITE:
  - wr_ready=1.
  - Per accepted beat (wr_valid&&wr_ready at an edge): mem_addr<=ptr, mem_data_in<=wr_data, mem_wen<=1. reg_mem commits the word on the following edge.
  - mem_wen is 0 in every cycle that does not follow an accepted beat. Gaps in wr_valid produce no writes.
  - ptr<=ptr+1, wrapping modulo 2^ADDR_BITS (all-ones wraps to 0).
  - If cnt==0 on the accepted beat: wr_ready<=0 and go to IDLE (cmd_ready<=1, busy<=0). Otherwise cnt<=cnt-1.
- Read, 4 cycles per beat:
  - RD_ADDR: mem_addr<=ptr, mem_wen stays 0; go to RD_WAIT.
  - RD_WAIT: one idle cycle; go to RD_CAP. This gives the required settle time whether reg_mem reads combinationally or registered.
  - RD_CAP: rd_data<=mem_data_out, rd_valid<=1; go to RD_OUT.
  - RD_OUT: hold rd_valid and rd_data stable until rd_valid&&rd_ready. On that edge rd_valid<=0.
    - If cnt==0, go to IDLE.
    - Otherwise ptr<=ptr+1 (wrapping), cnt<=cnt-1, and go to RD_ADDR.
  - rd_data keeps its last value after the handshake.
- Invariants:
  - mem_wen is never 1 during a read burst.
  - mem_addr holds its value when not updated.
  - wr_valid outside WRITE is ignored.
  - cmd_valid while busy is not accepted and not queued.
- Reset mid-burst:
  - Returns to IDLE at the reset edge and forces mem_wen to 0 from that edge.
  - Remaining beats are dropped; words already committed stay in reg_mem (reg_mem has no reset).
  - rd_valid drops even if the consumer has not taken the pending beat.
- Full-depth burst: cmd_len = all-ones visits every address exactly once, ending at start address minus one.

Test Plan:
- Reset: rst_n low for 3 edges with cmd_valid=1 and wr_valid=1 -> all outputs 0, mem_wen never 1. First edge after release -> cmd_ready=1, no command accepted before that.
- Basic: write cmd addr=12, len=7, wr_data 10..17 back-to-back -> 8 mem_wen pulses at addresses 12..19. Then read cmd addr=12, len=7 with rd_ready=1 -> rd_data 10..17 in order, one beat per 4 cycles.
- Wrap: write addr=30, len=3, data 0xA0..0xA3 -> mem_addr 30, 31, 0, 1. Read back addr=30, len=3 -> 0xA0..0xA3.
- Backpressure:
  - Write with wr_valid low on alternate cycles -> mem_wen only after accepted beats, no skipped or duplicated address.
  - Read with rd_ready low 5 cycles on beat 2 -> rd_valid, rd_data and mem_addr stable, exact sequence delivered.
- Command arbitration: len=0 write with cmd_valid held high -> one beat written, cmd_ready low while busy. Second command accepted only on the edge after return to IDLE.
- Reset mid-burst: write addr=12, len=7 with rst_n pulled low after 3 accepted beats -> mem_wen=0 from reset edge, addresses 12..14 hold new data, address 15 keeps prior content, busy=0.
